fifo_thresh: RTL and testbench
==============================

# fifo_thresh

Parametrised synchronous FIFO: the successor to the team's fixed-configuration FIFO. It adds run-time almost-full/almost-empty thresholds, full/empty flags, sticky overflow/underflow error flags with a clear input, and arbitrary (non-power-of-two) depth. It sits between producer and consumer blocks in one clock domain, as a drop-in replacement for the plain FIFO when flow-control back-pressure is needed.

## Interface

- WIDTH, 8, data word width in bits (≥1)
- DEPTH, 4, number of entries (≥2, any integer, not limited to powers of two)
- CW, $clog2(DEPTH)+1, width of count and threshold signals (derived, not overridden)

- clk_i  in  1  clock; all state changes on rising edge
- rst_i  in  1  reset, asynchronous, active-high
- data_i  in  WIDTH  write data
- setData_i  in  1  write request
- data_o  out  WIDTH  head-of-queue data (show-ahead)
- getData_i  in  1  read/pop request
- size_o  out  CW  current number of stored entries, 0..DEPTH
- full_o  out  1  size_o == DEPTH
- empty_o  out  1  size_o == 0
- afThresh_i  in  CW  almost-full threshold
- aeThresh_i  in  CW  almost-empty threshold
- almostFull_o  out  1  size_o >= afThresh_i
- almostEmpty_o  out  1  size_o <= aeThresh_i
- overflow_o  out  1  sticky: a write was lost
- underflow_o  out  1  sticky: a read was attempted while empty
- clrErr_i  in  1  synchronous clear of overflow_o/underflow_o

## Operation

- Storage: DEPTH×WIDTH register array; read pointer rdPtr, write pointer wrPtr, counter cnt; pointers wrap from DEPTH-1 to 0.
- Write accepted when setData_i=1 and (cnt<DEPTH or read accepted in the same cycle): mem[wrPtr]<=data_i, wrPtr advances.
- Read accepted when getData_i=1 and cnt>0: rdPtr advances. A read while empty has no effect except setting underflow_o.
- cnt: +1 on write-only, −1 on read-only, unchanged on both or neither.
- Simultaneous set+get while empty: write accepted, read rejected, underflow_o set, size_o becomes 1.
- Simultaneous set+get while full: both accepted, size_o stays DEPTH, no overflow.
- Write while full with no read: data dropped, overflow_o set (default build).
- data_o = mem[rdPtr] when cnt>0, else all zeros.
- Flags (full_o, empty_o, almostFull_o, almostEmpty_o) are combinational from the cnt register and threshold inputs; thresholds are compared unsigned and may change at any time.
- clrErr_i clears both sticky flags; if an error event occurs in the same cycle as clrErr_i, the error wins (flag stays/becomes 1).

## Timing

- Reset values: size_o=0, data_o=0, empty_o=1, full_o=0, overflow_o=0, underflow_o=0, pointers=0. almostEmpty_o=1 and almostFull_o=(afThresh_i==0), following the thresholds.
- Reset asserted mid-operation discards all contents immediately; memory contents are not cleared but are unobservable.
- Write-to-read latency: data written on edge N is visible on data_o after edge N when the FIFO was empty (zero-cycle show-ahead).
- size_o and all flags update on the edge that accepts the transfer; there is no extra pipeline stage.
- Sticky flags set on the edge of the offending request.

## Configuration

- FIFO_OVERWRITE_EN defined: a write while full with no read evicts the oldest entry. Both pointers advance, size_o stays DEPTH, the new data is stored, and overflow_o is set (the old data was lost).
- FIFO_OVERWRITE_EN undefined: a write while full is dropped and overflow_o is set; contents are unchanged.

## Test plan

- Reset, then write 0x11,0x22,0x33 (DEPTH=4) -> size_o=3, data_o=0x11; three pops return 0x11,0x22,0x33 in order, then empty_o=1 and data_o=0.
- Fill 4 entries, write 0x55 -> default build: overflow_o=1, head still first value; with FIFO_OVERWRITE_EN: head=second value, last pop returns 0x55.
- Pop while empty -> underflow_o=1, size_o=0; clrErr_i pulse -> flag 0; clrErr_i with a simultaneous empty pop -> flag stays 1.
- Full with simultaneous set/get for 10 cycles -> size_o=4 throughout, no overflow, FIFO order preserved across pointer wrap.
- afThresh_i=3, aeThresh_i=1: sizes 0..4 -> almostEmpty_o=1,1,0,0,0; almostFull_o=0,0,0,1,1.
- DEPTH=5 instance: 12 writes interleaved with reads to wrap twice -> data intact; assert rst_i mid-stream -> size_o=0, empty_o=1 without waiting for a clock edge.

Source files
------------

// File: rtl/fifo_thresh.sv
// fifo_thresh: single-clock FIFO with run-time almost-full/almost-empty
// thresholds, full/empty flags, sticky overflow/underflow error flags and
// support for any DEPTH >= 2, including depths that are not a power of two.
// Optional feature macro: FIFO_OVERWRITE_EN. When it is defined, a write to a
// full FIFO with no read evicts the oldest entry. When it is not defined, that
// write is dropped. Both builds set overflow_o.
module fifo_thresh #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             setData_i,
  output logic [WIDTH-1:0] data_o,
  input  logic             getData_i,
  output logic [CW-1:0]    size_o,
  output logic             full_o,
  output logic             empty_o,
  input  logic [CW-1:0]    afThresh_i,
  input  logic [CW-1:0]    aeThresh_i,
  output logic             almostFull_o,
  output logic             almostEmpty_o,
  output logic             overflow_o,
  output logic             underflow_o,
  input  logic             clrErr_i
);

  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_rdPtr;
  logic [PW-1:0]    r_wrPtr;
  logic [CW-1:0]    r_cnt;
  logic             r_overflow;
  logic             r_underflow;

  logic w_full;
  logic w_empty;
  logic w_rdAcc;
  logic w_wrAcc;
  logic w_evict;
  logic w_rdAdv;
  logic w_ovfEvent;
  logic w_unfEvent;

  // The pointers wrap explicitly at DEPTH-1, so any depth works.
  function automatic logic [PW-1:0] nextPtr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign w_full     = (r_cnt == CW'(DEPTH));
  assign w_empty    = (r_cnt == '0);
  assign w_rdAcc    = getData_i & ~w_empty;
  assign w_unfEvent = getData_i & w_empty;

`ifdef FIFO_OVERWRITE_EN
  // A write to a full FIFO with no read pushes the oldest entry out.
  assign w_evict    = setData_i & w_full & ~getData_i;
  assign w_wrAcc    = setData_i;
  assign w_ovfEvent = w_evict;
`else
  // A write to a full FIFO with no read is dropped.
  assign w_evict    = 1'b0;
  assign w_wrAcc    = setData_i & (~w_full | w_rdAcc);
  assign w_ovfEvent = setData_i & w_full & ~getData_i;
`endif

  // The read pointer moves on a real pop or on an eviction.
  assign w_rdAdv = w_rdAcc | w_evict;

  // Storage writes. The memory is not reset because stale words stay hidden behind r_cnt.
  always_ff @(posedge clk_i) begin
    if (w_wrAcc) begin
      r_mem[r_wrPtr] <= data_i;
    end
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_rdPtr <= '0;
      r_wrPtr <= '0;
      r_cnt   <= '0;
    end else begin
      if (w_wrAcc) begin
        r_wrPtr <= nextPtr(r_wrPtr);
      end
      if (w_rdAdv) begin
        r_rdPtr <= nextPtr(r_rdPtr);
      end
      if (w_wrAcc && !w_rdAdv) begin
        r_cnt <= r_cnt + 1'b1;
      end else if (w_rdAdv && !w_wrAcc) begin
        r_cnt <= r_cnt - 1'b1;
      end
    end
  end

  // Sticky error flags. An error in the same cycle as clrErr_i keeps the flag set.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (w_ovfEvent) begin
        r_overflow <= 1'b1;
      end else if (clrErr_i) begin
        r_overflow <= 1'b0;
      end
      if (w_unfEvent) begin
        r_underflow <= 1'b1;
      end else if (clrErr_i) begin
        r_underflow <= 1'b0;
      end
    end
  end

  assign data_o        = w_empty ? '0 : r_mem[r_rdPtr];
  assign size_o        = r_cnt;
  assign full_o        = w_full;
  assign empty_o       = w_empty;
  assign almostFull_o  = (r_cnt >= afThresh_i);
  assign almostEmpty_o = (r_cnt <= aeThresh_i);
  assign overflow_o    = r_overflow;
  assign underflow_o   = r_underflow;

endmodule

// File: tb/tb_fifo_thresh.sv
// tb_fifo_thresh: drives a DEPTH=4 and a DEPTH=5 fifo_thresh with the same
// transfers. Each output is compared against an ordered-list model of the queue.
module tb_fifo_thresh;

  logic       clk;
  logic       rst;
  logic [7:0] dataIn;
  logic       setData;
  logic       getData;
  logic       clrErr;

  logic [2:0] af4, ae4, size4;
  logic [3:0] af5, ae5, size5;
  logic [7:0] data4, data5;
  logic       full4, empty4, aFull4, aEmpty4, ovf4, unf4;
  logic       full5, empty5, aFull5, aEmpty5, ovf5, unf5;

  int checks = 0;
  int errors = 0;

  // Model: mArr[k][0] is the head and entries are in arrival order.
  logic [7:0] mArr [2][8];
  int         mCnt [2];
  logic       mOvf [2];
  logic       mUnf [2];

  fifo_thresh #(.WIDTH(8), .DEPTH(4)) dut4 (
    .clk_i(clk), .rst_i(rst), .data_i(dataIn), .setData_i(setData),
    .data_o(data4), .getData_i(getData), .size_o(size4), .full_o(full4),
    .empty_o(empty4), .afThresh_i(af4), .aeThresh_i(ae4),
    .almostFull_o(aFull4), .almostEmpty_o(aEmpty4), .overflow_o(ovf4),
    .underflow_o(unf4), .clrErr_i(clrErr)
  );

  fifo_thresh #(.WIDTH(8), .DEPTH(5)) dut5 (
    .clk_i(clk), .rst_i(rst), .data_i(dataIn), .setData_i(setData),
    .data_o(data5), .getData_i(getData), .size_o(size5), .full_o(full5),
    .empty_o(empty5), .afThresh_i(af5), .aeThresh_i(ae5),
    .almostFull_o(aFull5), .almostEmpty_o(aEmpty5), .overflow_o(ovf5),
    .underflow_o(unf5), .clrErr_i(clrErr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic modelClear();
    for (int k = 0; k < 2; k++) begin
      mCnt[k] = 0;
      mOvf[k] = 1'b0;
      mUnf[k] = 1'b0;
    end
  endtask

  task automatic modelPop(input int k);
    for (int i = 0; i < 7; i++) mArr[k][i] = mArr[k][i+1];
    mCnt[k]--;
  endtask

  task automatic modelPush(input int k, input logic [7:0] d);
    mArr[k][mCnt[k]] = d;
    mCnt[k]++;
  endtask

  // One clock edge of queue behaviour, computed from the pre-edge state.
  task automatic modelStep(input int k, input int depth, input logic s, input logic g,
                           input logic [7:0] d, input logic c);
    logic ovEv, unEv;
    ovEv = 1'b0;
    unEv = g && (mCnt[k] == 0);
    if (s && !g && mCnt[k] == depth) begin
      ovEv = 1'b1;
`ifdef FIFO_OVERWRITE_EN
      modelPop(k);
      modelPush(k, d);
`endif
    end else begin
      if (g && mCnt[k] > 0) modelPop(k);
      if (s) modelPush(k, d);
    end
    mOvf[k] = ovEv ? 1'b1 : (c ? 1'b0 : mOvf[k]);
    mUnf[k] = unEv ? 1'b1 : (c ? 1'b0 : mUnf[k]);
  endtask

  function automatic logic [7:0] expHead(input int k);
    return (mCnt[k] > 0) ? mArr[k][0] : 8'h00;
  endfunction

  task automatic checkAll();
    checkOutput("d4_size",   32'(size4),   32'(mCnt[0]));
    checkOutput("d4_data",   32'(data4),   32'(expHead(0)));
    checkOutput("d4_full",   32'(full4),   32'(mCnt[0] == 4));
    checkOutput("d4_empty",  32'(empty4),  32'(mCnt[0] == 0));
    checkOutput("d4_aFull",  32'(aFull4),  32'(mCnt[0] >= int'(af4)));
    checkOutput("d4_aEmpty", 32'(aEmpty4), 32'(mCnt[0] <= int'(ae4)));
    checkOutput("d4_ovf",    32'(ovf4),    32'(mOvf[0]));
    checkOutput("d4_unf",    32'(unf4),    32'(mUnf[0]));
    checkOutput("d5_size",   32'(size5),   32'(mCnt[1]));
    checkOutput("d5_data",   32'(data5),   32'(expHead(1)));
    checkOutput("d5_full",   32'(full5),   32'(mCnt[1] == 5));
    checkOutput("d5_empty",  32'(empty5),  32'(mCnt[1] == 0));
    checkOutput("d5_aFull",  32'(aFull5),  32'(mCnt[1] >= int'(af5)));
    checkOutput("d5_aEmpty", 32'(aEmpty5), 32'(mCnt[1] <= int'(ae5)));
    checkOutput("d5_ovf",    32'(ovf5),    32'(mOvf[1]));
    checkOutput("d5_unf",    32'(unf5),    32'(mUnf[1]));
  endtask

  // Drive one cycle of inputs at the falling edge, then check just after the rising edge.
  task automatic applyStimulus(input logic s, input logic g, input logic [7:0] d, input logic c);
    @(negedge clk);
    setData = s;
    getData = g;
    dataIn  = d;
    clrErr  = c;
    @(posedge clk);
    modelStep(0, 4, s, g, d, c);
    modelStep(1, 5, s, g, d, c);
    #1;
    checkAll();
  endtask

  // Reset must take effect at once, with no clock edge in between.
  task automatic doReset();
    @(negedge clk);
    setData = 1'b0;
    getData = 1'b0;
    clrErr  = 1'b0;
    rst     = 1'b1;
    modelClear();
    #1;
    checkOutput("rst_async_size4",  32'(size4),  32'd0);
    checkOutput("rst_async_empty4", 32'(empty4), 32'd1);
    checkOutput("rst_async_size5",  32'(size5),  32'd0);
    checkOutput("rst_async_empty5", 32'(empty5), 32'd1);
    checkAll();
    @(negedge clk);
    rst = 1'b0;
    #1;
    checkAll();
  endtask

  initial begin
    logic [7:0] expAe [5];
    logic [7:0] expAf [5];
    expAe = '{8'd1, 8'd1, 8'd0, 8'd0, 8'd0};
    expAf = '{8'd0, 8'd0, 8'd0, 8'd1, 8'd1};
    rst = 1'b1; setData = 1'b0; getData = 1'b0; clrErr = 1'b0; dataIn = 8'h00;
    af4 = 3'd3; ae4 = 3'd1; af5 = 4'd4; ae5 = 4'd1;
    modelClear();
    #2;
    doReset();
    checkOutput("reset_data4", 32'(data4), 32'h0);
    checkOutput("reset_aFull4", 32'(aFull4), 32'd0);

    // Three writes, then three pops in FIFO order.
    applyStimulus(1'b1, 1'b0, 8'h11, 1'b0);
    checkOutput("showahead_first", 32'(data4), 32'h11);
    applyStimulus(1'b1, 1'b0, 8'h22, 1'b0);
    applyStimulus(1'b1, 1'b0, 8'h33, 1'b0);
    checkOutput("tp1_size", 32'(size4), 32'd3);
    checkOutput("tp1_head", 32'(data4), 32'h11);
    applyStimulus(1'b0, 1'b1, 8'h00, 1'b0);
    checkOutput("tp1_pop1", 32'(data4), 32'h22);
    applyStimulus(1'b0, 1'b1, 8'h00, 1'b0);
    applyStimulus(1'b0, 1'b1, 8'h00, 1'b0);
    checkOutput("tp1_empty", 32'(empty4), 32'd1);
    checkOutput("tp1_data0", 32'(data4), 32'h0);

    // Threshold sweep af=3, ae=1 over sizes 0..4, then the overflow write.
    for (int i = 0; i < 5; i++) begin
      checkOutput("thr_aEmpty", 32'(aEmpty4), 32'(expAe[i]));
      checkOutput("thr_aFull",  32'(aFull4),  32'(expAf[i]));
      if (i < 4) applyStimulus(1'b1, 1'b0, 8'hA0 + 8'(i), 1'b0);
    end
    applyStimulus(1'b1, 1'b0, 8'h55, 1'b0);
    checkOutput("ovf_flag", 32'(ovf4), 32'd1);
    checkOutput("ovf_size", 32'(size4), 32'd4);
`ifdef FIFO_OVERWRITE_EN
    checkOutput("ovf_head", 32'(data4), 32'hA1);
`else
    checkOutput("ovf_head", 32'(data4), 32'hA0);
`endif

    // Full, with a simultaneous set and get for 10 cycles.
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b1, 1'b1, 8'hC0 + 8'(i), 1'b0);
      checkOutput("fullrw_size", 32'(size4), 32'd4);
    end
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);
    checkOutput("clr_ovf", 32'(ovf4), 32'd0);

    // Drain, pop while empty, clear the error, then clear it during an empty pop.
    for (int i = 0; i < 6; i++) applyStimulus(1'b0, 1'b1, 8'h00, 1'b0);
    checkOutput("unf_flag", 32'(unf4), 32'd1);
    checkOutput("unf_size", 32'(size4), 32'd0);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);
    checkOutput("unf_clr", 32'(unf4), 32'd0);
    applyStimulus(1'b0, 1'b1, 8'h00, 1'b1);
    checkOutput("unf_clr_wins", 32'(unf4), 32'd1);
    applyStimulus(1'b1, 1'b1, 8'h77, 1'b0);
    checkOutput("setget_empty_size", 32'(size4), 32'd1);
    checkOutput("setget_empty_data", 32'(data4), 32'h77);

    // Random traffic with changing thresholds and one reset in mid-stream.
    for (int i = 0; i < 400; i++) begin
      if (i % 16 == 0) begin
        af4 = 3'($urandom_range(0, 7));
        ae4 = 3'($urandom_range(0, 7));
        af5 = 4'($urandom_range(0, 15));
        ae5 = 4'($urandom_range(0, 15));
      end
      if (i == 200) doReset();
      applyStimulus(1'($urandom_range(0, 99) < 55), 1'($urandom_range(0, 99) < 45),
                    8'($urandom), 1'($urandom_range(0, 9) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
